udp_jpeg_pkt_sched: RTL and testbench

UDP_JPEG_PKT_SCHED -- requirements
Module: udp_jpeg_pkt_sched

---
 rtl/udp_sched_pkg.sv | 27 ++
 rtl/udp_jpeg_pkt_sched_if.sv | 39 +++
 rtl/udp_sched_timer.sv | 34 +++
 rtl/udp_jpeg_pkt_sched.sv | 182 ++++++++++++++++++
 tb/tb_udp_jpeg_pkt_sched.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_sched_pkg.sv
// ============================================================================
// Module      : udp_sched_pkg
// Description : Shared state encoding and parameter defaults for the UDP JPEG
//               packet scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package udp_sched_pkg;

    localparam int unsigned DEF_MAX_PAYLOAD    = 1024;
    localparam int unsigned DEF_IPG_CYCLES     = 64;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD      = 4'd1,
        ST_ISSUE     = 4'd2,
        ST_WAIT_BUSY = 4'd3,
        ST_WAIT_DONE = 4'd4,
        ST_GAP       = 4'd5,
        ST_DONE      = 4'd6
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/udp_jpeg_pkt_sched_if.sv
// ============================================================================
// Module      : udp_jpeg_pkt_sched_if
// Description : Frame-source and packet-sender signals of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface udp_jpeg_pkt_sched_if;

    logic        i_frame_start;
    logic [31:0] i_frame_bytes;
    logic        o_frame_ack;
    logic        o_frame_done;
    logic        o_busy;
    logic        o_send_en;
    logic [15:0] o_pkt_len;
    logic        o_last_flag;
    logic [14:0] o_pkt_rank;
    logic [15:0] o_ipv4_sign;
    logic [31:0] o_rd_offset;
    logic        i_send_busy;
    logic        o_timeout_err;

    // The environment (frame source + sender) drives the i_* signals.
    modport master (
        output i_frame_start, i_frame_bytes, i_send_busy,
        input  o_frame_ack, o_frame_done, o_busy, o_send_en, o_pkt_len,
               o_last_flag, o_pkt_rank, o_ipv4_sign, o_rd_offset, o_timeout_err
    );

    modport slave (
        input  i_frame_start, i_frame_bytes, i_send_busy,
        output o_frame_ack, o_frame_done, o_busy, o_send_en, o_pkt_len,
               o_last_flag, o_pkt_rank, o_ipv4_sign, o_rd_offset, o_timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/udp_sched_timer.sv
// ============================================================================
// Module      : udp_sched_timer
// Description : 16-bit cycle counter shared by the inter-packet gap and the
//               sender watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_sched_timer (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        clear_i,
    input  wire logic        enable_i,
    input  wire logic [15:0] cmp_i,
    output logic             eq_o
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign eq_o = (cnt_q == cmp_i);

endmodule

`default_nettype wire

// File: rtl/udp_jpeg_pkt_sched.sv
// ============================================================================
// Module      : udp_jpeg_pkt_sched
// Description : Splits a buffered JPEG frame into UDP payload packets and
//               paces their issue to the packet sender.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_jpeg_pkt_sched
    import udp_sched_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD    = DEF_MAX_PAYLOAD,
    parameter int unsigned IPG_CYCLES     = DEF_IPG_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  wire logic            i_udp_clk50m,
    input  wire logic            i_rst_n,
    udp_jpeg_pkt_sched_if.slave  bus
);

    localparam logic [31:0] c_max_len32 = 32'(MAX_PAYLOAD);
    localparam logic [15:0] c_max_len16 = 16'(MAX_PAYLOAD);
    localparam logic [15:0] c_gap_last  = (IPG_CYCLES == 0) ? 16'd0 : 16'(IPG_CYCLES - 1);
    localparam logic [15:0] c_wd_last   = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);
    localparam sched_state_t c_after_pkt = (IPG_CYCLES == 0) ? ST_LOAD : ST_GAP;

    sched_state_t state_q, state_d;
    logic [31:0]  remaining_q, remaining_d;
    logic [31:0]  offset_q, offset_d;
    logic [14:0]  rank_q, rank_d;
    logic [15:0]  sign_q, sign_d;
    logic [15:0]  len_q, len_d;
    logic         last_q, last_d;
    logic         ack_q, ack_d;
    logic         done_q, done_d;
    logic         send_q, send_d;
    logic         tmo_q, tmo_d;
    logic         busy_q;

    logic         w_tmr_clear;
    logic         w_tmr_en;
    logic [15:0]  w_tmr_cmp;
    logic         w_tmr_eq;

    // Any state change restarts the count, so each timed state starts at zero.
    assign w_tmr_clear = (state_d != state_q);
    assign w_tmr_en    = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE) ||
                         (state_q == ST_GAP);
    assign w_tmr_cmp   = (state_q == ST_GAP) ? c_gap_last : c_wd_last;

    udp_sched_timer u_timer (
        .clk_i    (i_udp_clk50m),
        .rst_ni   (i_rst_n),
        .clear_i  (w_tmr_clear),
        .enable_i (w_tmr_en),
        .cmp_i    (w_tmr_cmp),
        .eq_o     (w_tmr_eq)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        offset_d    = offset_q;
        rank_d      = rank_q;
        sign_d      = sign_q;
        len_d       = len_q;
        last_d      = last_q;
        ack_d       = 1'b0;
        done_d      = 1'b0;
        send_d      = 1'b0;
        tmo_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_frame_start) begin
                    ack_d = 1'b1;
                    if (bus.i_frame_bytes == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        remaining_d = bus.i_frame_bytes;
                        rank_d      = '0;
                        offset_d    = '0;
                        state_d     = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                len_d   = (remaining_q > c_max_len32) ? c_max_len16 : remaining_q[15:0];
                last_d  = (remaining_q <= c_max_len32);
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                send_d  = 1'b1;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.i_send_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (w_tmr_eq) begin
                    tmo_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.i_send_busy) begin
                    remaining_d = (remaining_q >= {16'd0, len_q}) ?
                                  (remaining_q - {16'd0, len_q}) : 32'd0;
                    offset_d    = offset_q + {16'd0, len_q};
                    rank_d      = rank_q + 15'd1;
                    sign_d      = sign_q + 16'd1;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = c_after_pkt;
                    end
                end else if (w_tmr_eq) begin
                    // Abort leaves rank and identification at the failed packet.
                    tmo_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_GAP: begin
                if (w_tmr_eq) begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            offset_q    <= '0;
            rank_q      <= '0;
            sign_q      <= '0;
            len_q       <= '0;
            last_q      <= 1'b0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            send_q      <= 1'b0;
            tmo_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            rank_q      <= rank_d;
            sign_q      <= sign_d;
            len_q       <= len_d;
            last_q      <= last_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            send_q      <= send_d;
            tmo_q       <= tmo_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign bus.o_frame_ack   = ack_q;
    assign bus.o_frame_done  = done_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_send_en     = send_q;
    assign bus.o_pkt_len     = len_q;
    assign bus.o_last_flag   = last_q;
    assign bus.o_pkt_rank    = rank_q;
    assign bus.o_ipv4_sign   = sign_q;
    assign bus.o_rd_offset   = offset_q;
    assign bus.o_timeout_err = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_udp_jpeg_pkt_sched.sv
// ============================================================================
// Module      : tb_udp_jpeg_pkt_sched
// Description : Self-checking bench for udp_jpeg_pkt_sched with a frame-level
//               packetisation model and a reactive sender.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udp_jpeg_pkt_sched;

    localparam int MAX_P = 1024;
    localparam int IPG   = 64;
    localparam int TMO   = 65535;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_sign = 16'd0;
    logic [84:0] all_outs;

    udp_jpeg_pkt_sched_if bus ();

    udp_jpeg_pkt_sched #(
        .MAX_PAYLOAD    (MAX_P),
        .IPG_CYCLES     (IPG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_udp_clk50m (clk),
        .i_rst_n      (rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    assign all_outs = {bus.o_frame_ack, bus.o_frame_done, bus.o_busy, bus.o_send_en,
                       bus.o_pkt_len, bus.o_last_flag, bus.o_pkt_rank, bus.o_ipv4_sign,
                       bus.o_rd_offset, bus.o_timeout_err};

    // Packet descriptor expected for packet k of a frame, from plain arithmetic.
    function automatic logic [79:0] pkt_model(input int bytes, input int k, input logic [15:0] sign0);
        int rem;
        int len;
        int npk;
        rem = bytes - k * MAX_P;
        len = (rem > MAX_P) ? MAX_P : rem;
        npk = (bytes + MAX_P - 1) / MAX_P;
        return {16'(len), (k == npk - 1), 15'(k), 16'(sign0 + 16'(k)), 32'(k * MAX_P)};
    endfunction

    task automatic test_reset;
        bus.i_frame_start = 1'b0;
        bus.i_frame_bytes = 32'd0;
        bus.i_send_busy   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (all_outs !== 85'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (all_outs !== 85'd0) begin
            fails++;
            $display("FAIL reset_release_idle: got %h expected 0", all_outs);
        end
        exp_sign = 16'd0;
    endtask

    // Runs one frame with a sender that raises busy bdly cycles after each
    // strobe and holds it blen+1 cycles; a stray start is injected mid-frame.
    task automatic run_frame(input int bytes, input int bdly, input int blen, input int inject_at);
        int npk, sends, acks, last_send, phase, cnt;
        bit fin;
        logic [15:0] sign0;
        logic [79:0] exp_v, act_v;
        npk = (bytes + MAX_P - 1) / MAX_P;
        sign0 = exp_sign;
        sends = 0; acks = 0; last_send = 0; phase = 0; cnt = 0; fin = 1'b0;

        bus.i_frame_start = 1'b1;
        bus.i_frame_bytes = 32'(bytes);
        @(posedge clk); #1;
        bus.i_frame_start = 1'b0;
        tests++;
        if ({bus.o_frame_ack, bus.o_send_en} !== 2'b10) begin
            fails++;
            $display("FAIL ack_latency bytes=%0d: got ack/send %b expected 10", bytes, {bus.o_frame_ack, bus.o_send_en});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (bus.o_send_en !== 1'b1) begin
            fails++;
            $display("FAIL send_latency bytes=%0d: got %b expected 1", bytes, bus.o_send_en);
        end

        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            if (bus.o_frame_ack) acks++;
            if (bus.o_send_en) begin
                exp_v = pkt_model(bytes, sends, sign0);
                act_v = {bus.o_pkt_len, bus.o_last_flag, bus.o_pkt_rank, bus.o_ipv4_sign, bus.o_rd_offset};
                tests++;
                if (act_v !== exp_v) begin
                    fails++;
                    $display("FAIL pkt%0d bytes=%0d: got %h expected %h", sends, bytes, act_v, exp_v);
                end
                if (sends > 0) begin
                    tests++;
                    if (cyc - last_send < IPG) begin
                        fails++;
                        $display("FAIL send_spacing: got %0d cycles expected >= %0d", cyc - last_send, IPG);
                    end
                end
                last_send = cyc;
                sends++;
                phase = 1;
                cnt = bdly;
            end else if (phase == 1) begin
                if (cnt == 0) begin
                    bus.i_send_busy = 1'b1;
                    phase = 2;
                    cnt = blen;
                end else cnt--;
            end else if (phase == 2) begin
                if (cnt == 0) begin
                    exp_v = pkt_model(bytes, sends - 1, sign0);
                    act_v = {bus.o_pkt_len, bus.o_last_flag, bus.o_pkt_rank, bus.o_ipv4_sign, bus.o_rd_offset};
                    tests++;
                    if (act_v !== exp_v) begin
                        fails++;
                        $display("FAIL pkt_hold%0d: got %h expected %h", sends - 1, act_v, exp_v);
                    end
                    bus.i_send_busy = 1'b0;
                    phase = 0;
                end else cnt--;
            end
            if (bus.o_frame_done) fin = 1'b1;
            if (cyc == inject_at) begin
                bus.i_frame_start = 1'b1;
                bus.i_frame_bytes = 32'($urandom_range(1, 9000));
            end else begin
                bus.i_frame_start = 1'b0;
            end
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        bus.i_frame_start = 1'b0;
        bus.i_send_busy   = 1'b0;
        exp_sign = sign0 + 16'(npk);

        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL frame_done_timeout bytes=%0d: got no done expected done", bytes);
        end
        tests++;
        if (sends != npk || acks != 0) begin
            fails++;
            $display("FAIL frame_counts bytes=%0d: got sends=%0d acks=%0d expected sends=%0d acks=0", bytes, sends, acks, npk);
        end
        tests++;
        if (bus.o_ipv4_sign !== exp_sign) begin
            fails++;
            $display("FAIL sign_end bytes=%0d: got %0d expected %0d", bytes, bus.o_ipv4_sign, exp_sign);
        end
        @(posedge clk); #1;
        tests++;
        if ({bus.o_frame_done, bus.o_busy} !== 2'b00) begin
            fails++;
            $display("FAIL back_to_idle bytes=%0d: got done/busy %b expected 00", bytes, {bus.o_frame_done, bus.o_busy});
        end
    endtask

    task automatic test_three_packet;
        run_frame(2500, 1, 3, 4);
        tests++;
        if (bus.o_ipv4_sign !== 16'd3) begin
            fails++;
            $display("FAIL three_pkt_sign: got %0d expected 3", bus.o_ipv4_sign);
        end
    endtask

    task automatic test_exact_fit;
        run_frame(1024, 0, 0, 2);
    endtask

    task automatic test_empty;
        bit bad;
        bad = 1'b0;
        bus.i_frame_start = 1'b1;
        bus.i_frame_bytes = 32'd0;
        @(posedge clk); #1;
        bus.i_frame_start = 1'b0;
        tests++;
        if ({bus.o_frame_ack, bus.o_frame_done, bus.o_busy} !== 3'b110) begin
            fails++;
            $display("FAIL empty_ack_done: got ack/done/busy %b expected 110", {bus.o_frame_ack, bus.o_frame_done, bus.o_busy});
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.o_send_en || bus.o_busy || bus.o_frame_done) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL empty_no_send: got activity expected none");
        end
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 6; f++) begin
            run_frame(int'($urandom_range(1, 5000)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 5)), int'($urandom_range(1, 6)));
        end
    endtask

    task automatic test_timeout;
        int n;
        bit seen_send, seen_done;
        logic [15:0] sign0;
        sign0 = exp_sign;
        seen_send = 1'b0;
        bus.i_send_busy   = 1'b0;
        bus.i_frame_start = 1'b1;
        bus.i_frame_bytes = 32'd3000;
        @(posedge clk); #1;
        bus.i_frame_start = 1'b0;
        for (int i = 0; i < 10 && !seen_send; i++) begin
            @(posedge clk); #1;
            seen_send = bus.o_send_en;
        end
        n = 0;
        if (seen_send) begin
            for (n = 1; n <= TMO + 100; n++) begin
                @(posedge clk); #1;
                if (bus.o_timeout_err) break;
            end
        end
        tests++;
        if (n != TMO) begin
            fails++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TMO);
        end
        seen_done = bus.o_frame_done;
        if (!seen_done) begin
            @(posedge clk); #1;
            seen_done = bus.o_frame_done;
        end
        tests++;
        if (!seen_done) begin
            fails++;
            $display("FAIL timeout_done: got 0 expected 1");
        end
        tests++;
        if ({bus.o_ipv4_sign, bus.o_pkt_rank} !== {sign0, 15'd0}) begin
            fails++;
            $display("FAIL timeout_sign_rank: got %0d/%0d expected %0d/0", bus.o_ipv4_sign, bus.o_pkt_rank, sign0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (bus.o_busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: got busy %b expected 0", bus.o_busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit seen_send, bad;
        seen_send = 1'b0;
        bad = 1'b0;
        bus.i_frame_start = 1'b1;
        bus.i_frame_bytes = 32'd2500;
        @(posedge clk); #1;
        bus.i_frame_start = 1'b0;
        for (int i = 0; i < 10 && !seen_send; i++) begin
            @(posedge clk); #1;
            seen_send = bus.o_send_en;
        end
        bus.i_send_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (!seen_send || all_outs !== 85'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got send_seen=%b outs=%h expected 1/0", seen_send, all_outs);
        end
        bus.i_send_busy = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.o_frame_done || bus.o_busy) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reset_mid_no_done: got activity expected none");
        end
        exp_sign = 16'd0;
        run_frame(1500, 2, 1, 3);
    endtask

    initial begin
        test_reset();
        test_three_packet();
        test_exact_fit();
        test_empty();
        test_random_frames();
        test_timeout();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
